// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback path: widths, PPP encodings, writeback request.
package rf_pkg;

  localparam int RF_DATA_WIDTH = 64;
  localparam int RF_ADDR_WIDTH = 5;

  typedef logic [2:0] ppp_t;

  localparam ppp_t PPP_A = 3'b000;
  localparam ppp_t PPP_U = 3'b001;
  localparam ppp_t PPP_D = 3'b010;
  localparam ppp_t PPP_E = 3'b011;
  localparam ppp_t PPP_O = 3'b100;

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] rd;
    ppp_t                     ppp;
    logic [RF_DATA_WIDTH-1:0] data;
  } wb_req_t;

  // Encodings above PPP_O are reserved and must never reach the register file.
  function automatic logic ppp_is_valid(input ppp_t p);
    return p <= PPP_O;
  endfunction

endpackage

// File: rtl/ld_rsp_fifo.sv
// In-order synchronous FIFO for returned load data; one-cycle write-to-read latency.
// Caller must not push when full nor pop when empty; same-cycle push and pop is allowed.
module ld_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU results and queued load returns onto the single register-file write port, with a
// pending-load scoreboard for decode hazards. Optional WB_ERR_COUNT_EN adds a saturating drop counter.
module rf_writeback_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH,
  parameter int LQ_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [2:0]            alu_ppp,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  ld_issue_valid,
  input  logic [ADDR_WIDTH-1:0] ld_issue_rd,
  output logic                  ld_issue_ready,
  input  logic                  ld_rsp_valid,
  output logic                  ld_rsp_ready,
  input  logic [ADDR_WIDTH-1:0] ld_rsp_rd,
  input  logic [2:0]            ld_rsp_ppp,
  input  logic [DATA_WIDTH-1:0] ld_rsp_data,
  input  logic [ADDR_WIDTH-1:0] hz_rd_0,
  input  logic [ADDR_WIDTH-1:0] hz_rd_1,
  output logic                  hz_busy_0,
  output logic                  hz_busy_1,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [2:0]            rf_ppp_sel,
  output logic [DATA_WIDTH-1:0] rf_data,
  output logic                  ppp_err
`ifdef WB_ERR_COUNT_EN
  ,
  output logic [15:0]           ppp_err_cnt
`endif
);

  localparam int CW = $clog2(LQ_DEPTH + 1);

  wb_req_t             alu_req;
  wb_req_t             rsp_req;
  wb_req_t             head_req;
  wb_req_t             sel_req;
  logic [CW-1:0]       lq_count;
  logic                lq_full;
  logic                lq_empty;
  logic                lq_push;
  logic                lq_pop;
  logic                take_alu;
  logic                wr_any;
  logic                bad_ppp;
  logic                issue_set;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  assign alu_req = '{rd: alu_rd, ppp: alu_ppp, data: alu_data};
  assign rsp_req = '{rd: ld_rsp_rd, ppp: ld_rsp_ppp, data: ld_rsp_data};

  ld_rsp_fifo #(
    .WIDTH ($bits(wb_req_t)),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .reset     (reset),
    .push      (lq_push),
    .push_data (rsp_req),
    .pop       (lq_pop),
    .pop_data  (head_req),
    .count     (lq_count),
    .full      (lq_full),
    .empty     (lq_empty)
  );

  // A full queue outranks the ALU so loads can never be starved indefinitely.
  assign ld_rsp_ready = (lq_count < CW'(LQ_DEPTH));
  assign alu_ready    = !lq_full;
  assign lq_push      = ld_rsp_valid && ld_rsp_ready;
  assign lq_pop       = lq_full || (!alu_valid && !lq_empty);
  assign take_alu     = alu_valid && !lq_full;
  assign wr_any       = take_alu || lq_pop;
  assign sel_req      = take_alu ? alu_req : head_req;
  assign bad_ppp      = wr_any && !ppp_is_valid(sel_req.ppp);

  // A re-issue to a register whose load is retiring this cycle is safe: clear then set.
  assign ld_issue_ready = !pending[ld_issue_rd] || (lq_pop && (head_req.rd == ld_issue_rd));
  assign issue_set      = ld_issue_valid && ld_issue_ready && (ld_issue_rd != '0);

  always_comb begin
    pending_nxt = pending;
    if (lq_pop)    pending_nxt[head_req.rd] = 1'b0;
    if (issue_set) pending_nxt[ld_issue_rd] = 1'b1;
  end

  assign hz_busy_0 = pending[hz_rd_0];
  assign hz_busy_1 = pending[hz_rd_1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wen     <= 1'b0;
      rf_wr_addr <= '0;
      rf_ppp_sel <= '0;
      rf_data    <= '0;
      ppp_err    <= 1'b0;
      pending    <= '0;
    end else begin
      rf_wen  <= wr_any && (sel_req.rd != '0) && ppp_is_valid(sel_req.ppp);
      pending <= pending_nxt;
      if (wr_any) begin
        rf_wr_addr <= sel_req.rd;
        rf_ppp_sel <= sel_req.ppp;
        rf_data    <= sel_req.data;
      end
      if (bad_ppp) ppp_err <= 1'b1;
    end
  end

`ifdef WB_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ppp_err_cnt <= '0;
    end else if (bad_ppp && (ppp_err_cnt != 16'hFFFF)) begin
      ppp_err_cnt <= ppp_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomised scoreboard bench: a queue-based reference model predicts each cycle's write and flags.
module tb_rf_writeback_arbiter;
  import rf_pkg::*;

  localparam int LQD = 2;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [2:0]  alu_ppp;
  logic [63:0] alu_data;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        ld_rsp_valid;
  logic        ld_rsp_ready;
  logic [4:0]  ld_rsp_rd;
  logic [2:0]  ld_rsp_ppp;
  logic [63:0] ld_rsp_data;
  logic [4:0]  hz_rd_0;
  logic [4:0]  hz_rd_1;
  logic        hz_busy_0;
  logic        hz_busy_1;
  logic        rf_wen;
  logic [4:0]  rf_wr_addr;
  logic [2:0]  rf_ppp_sel;
  logic [63:0] rf_data;
  logic        ppp_err;
`ifdef WB_ERR_COUNT_EN
  logic [15:0] ppp_err_cnt;
`endif

  rf_writeback_arbiter #(.LQ_DEPTH(LQD)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_ppp        (alu_ppp),
    .alu_data       (alu_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_rsp_valid   (ld_rsp_valid),
    .ld_rsp_ready   (ld_rsp_ready),
    .ld_rsp_rd      (ld_rsp_rd),
    .ld_rsp_ppp     (ld_rsp_ppp),
    .ld_rsp_data    (ld_rsp_data),
    .hz_rd_0        (hz_rd_0),
    .hz_rd_1        (hz_rd_1),
    .hz_busy_0      (hz_busy_0),
    .hz_busy_1      (hz_busy_1),
    .rf_wen         (rf_wen),
    .rf_wr_addr     (rf_wr_addr),
    .rf_ppp_sel     (rf_ppp_sel),
    .rf_data        (rf_data),
    .ppp_err        (ppp_err)
`ifdef WB_ERR_COUNT_EN
    ,
    .ppp_err_cnt    (ppp_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wen;
    logic [4:0]  addr;
    logic [2:0]  ppp;
    logic [63:0] data;
    bit          err;
    int          cnt;
  } exp_t;

  exp_t      eq[$];
  wb_req_t   mq[$];
  bit [31:0] mpend;
  bit        merr;
  int        mcnt;
  int        n_vec;
  int        n_cmp;
  int        n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered outputs: one expectation per cycle, popped at the negedge after the edge.
  always @(negedge clk) begin
    if (eq.size() > 0) begin
      exp_t e;
      e = eq.pop_front();
      chk("rf_wen", rf_wen, e.wen);
      if (e.wen) begin
        chk("rf_wr_addr", rf_wr_addr, e.addr);
        chk("rf_ppp_sel", rf_ppp_sel, e.ppp);
        chk("rf_data", rf_data, e.data);
      end
      chk("ppp_err", ppp_err, e.err);
`ifdef WB_ERR_COUNT_EN
      chk("ppp_err_cnt", ppp_err_cnt, e.cnt);
`endif
    end
  end

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic cycle();
    bit      full;
    bit      have;
    bit      isld;
    bit      irdy;
    wb_req_t w;
    exp_t    e;
    #1;
    full = (mq.size() == LQD);
    have = 0;
    isld = 0;
    w    = '0;
    if (full || (!alu_valid && mq.size() > 0)) begin
      w = mq[0]; have = 1; isld = 1;
    end else if (alu_valid) begin
      w = '{rd: alu_rd, ppp: alu_ppp, data: alu_data}; have = 1;
    end
    irdy = !mpend[ld_issue_rd] || (isld && w.rd == ld_issue_rd);
    chk("alu_ready", alu_ready, !full);
    chk("ld_rsp_ready", ld_rsp_ready, !full);
    chk("ld_issue_ready", ld_issue_ready, irdy);
    chk("hz_busy_0", hz_busy_0, mpend[hz_rd_0]);
    chk("hz_busy_1", hz_busy_1, mpend[hz_rd_1]);
    e = '{wen: 0, addr: 0, ppp: 0, data: 0, err: 0, cnt: 0};
    if (reset) begin
      mq.delete();
      mpend = '0;
      merr  = 0;
      mcnt  = 0;
    end else begin
      if (isld) begin
        void'(mq.pop_front());
        mpend[w.rd] = 0;
      end
      if (ld_issue_valid && irdy && ld_issue_rd != 0) mpend[ld_issue_rd] = 1;
      if (ld_rsp_valid && !full)
        mq.push_back('{rd: ld_rsp_rd, ppp: ld_rsp_ppp, data: ld_rsp_data});
      e.wen  = have && w.rd != 0 && w.ppp <= 3'd4;
      e.addr = w.rd;
      e.ppp  = w.ppp;
      e.data = w.data;
      if (have && w.ppp > 3'd4) begin
        merr = 1;
        if (mcnt < 65535) mcnt++;
      end
    end
    e.err = merr;
    e.cnt = mcnt;
    eq.push_back(e);
    n_vec++;
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; alu_valid = 0; ld_issue_valid = 0; ld_rsp_valid = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [2:0] p, input logic [63:0] d);
    alu_valid = 1; alu_rd = rd; alu_ppp = p; alu_data = d;
  endtask

  task automatic rsp(input logic [4:0] rd, input logic [2:0] p, input logic [63:0] d);
    ld_rsp_valid = 1; ld_rsp_rd = rd; ld_rsp_ppp = p; ld_rsp_data = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    ld_issue_valid = 1; ld_issue_rd = rd;
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_fail = 0; mpend = '0; merr = 0; mcnt = 0;
    reset = 1; alu_valid = 0; alu_rd = 0; alu_ppp = 0; alu_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0; ld_rsp_valid = 0; ld_rsp_rd = 0;
    ld_rsp_ppp = 0; ld_rsp_data = 0; hz_rd_0 = 0; hz_rd_1 = 0;
    @(negedge clk);
    cycle(); cycle();

    // ALU only
    idle(); alu(5'd7, PPP_A, 64'h1122334455667788); cycle();
    idle(); cycle();

    // Load hazard on r9, re-issue blocked, retire with PPP_U
    hz_rd_0 = 5'd9; hz_rd_1 = 5'd3;
    idle(); issue(5'd9); cycle();
    idle(); cycle();
    idle(); issue(5'd9); cycle();
    idle(); rsp(5'd9, PPP_U, 64'hDEAD_BEEF_0000_0009); cycle();
    idle(); cycle(); cycle();

    // Queue fills while ALU is held valid
    idle(); issue(5'd3); alu(5'd1, PPP_D, 64'hA1); rsp(5'd3, PPP_E, 64'hB3); cycle();
    idle(); alu(5'd2, PPP_D, 64'hA2); rsp(5'd5, PPP_O, 64'hB5); cycle();
    for (int i = 0; i < 5; i++) begin
      idle(); alu(5'(10 + i), PPP_A, 64'(i)); cycle();
    end

    // One queued entry vs ALU, then same-cycle push and pop
    idle(); alu(5'd11, PPP_A, 64'hC1); rsp(5'd12, PPP_U, 64'hD1); cycle();
    idle(); alu(5'd13, PPP_A, 64'hC2); cycle();
    idle(); rsp(5'd14, PPP_D, 64'hD2); cycle();
    idle(); rsp(5'd15, PPP_E, 64'hD3); cycle();
    idle(); cycle(); cycle();

    // r0 and invalid PPP drops
    hz_rd_0 = 5'd4;
    idle(); alu(5'd0, PPP_A, 64'hFF); issue(5'd4); cycle();
    idle(); rsp(5'd4, 3'b110, 64'hEE); cycle();
    idle(); cycle(); cycle();

    // Reset with two queued loads and three pending registers
    hz_rd_0 = 5'd6; hz_rd_1 = 5'd8;
    idle(); issue(5'd6); cycle();
    idle(); issue(5'd7); alu(5'd1, PPP_A, 64'h1); cycle();
    idle(); issue(5'd8); alu(5'd1, PPP_A, 64'h2); rsp(5'd6, PPP_A, 64'h6); cycle();
    idle(); alu(5'd1, PPP_A, 64'h3); rsp(5'd7, PPP_A, 64'h7); cycle();
    idle(); reset = 1; cycle();
    idle(); cycle(); cycle();

    // Randomised traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      idle();
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 1)
        alu(5'($urandom_range(0, 15)), 3'($urandom_range(0, 5)), {$urandom, $urandom});
      if ($urandom_range(0, 9) < 3) issue(5'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) < 4)
        rsp(5'($urandom_range(0, 15)), 3'($urandom_range(0, 5)), {$urandom, $urandom});
      if (alu_valid && alu_ppp > 3'd4 && alu_rd == 0) alu_rd = 5'd1;
      if (ld_rsp_valid && ld_rsp_ppp > 3'd4 && ld_rsp_rd == 0) ld_rsp_rd = 5'd1;
      hz_rd_0 = 5'($urandom_range(0, 15));
      hz_rd_1 = 5'($urandom_range(0, 15));
      cycle();
    end

    idle();
    #2;
    if (eq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", eq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
